jtag_scan_ctrl: RTL

- Command-driven JTAG master that sequences the team's `jtag` TAP controller by generating TMS/TDI and capturing TDO.
- Accepts one command at a time: TAP reset, IR scan, DR scan or idle run. Walks the TAP through the required states and returns the captured shift data.
- Shares clk/reset with the TAP. It keeps an internal model of the TAP state that mirrors the real TAP cycle-for-cycle.

---
 rtl/jtag_scan_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jtag_scan_ctrl
// Description : Command-driven JTAG master; walks a same-clock TAP through
//               reset / IR scan / DR scan / idle-run sequences and returns TDO.
//               Optional macro JTAG_SCAN_PAUSE_EN adds shift_hold (PAUSE_xR).
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_scan_ctrl #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [3:0]        tap_state
`ifdef JTAG_SCAN_PAUSE_EN
    ,
    input  logic              shift_hold
`endif
);

    localparam logic [3:0] c_tlr    = 4'd0;
    localparam logic [3:0] c_rti    = 4'd1;
    localparam logic [3:0] c_sel_dr = 4'd2;
    localparam logic [3:0] c_cap_dr = 4'd3;
    localparam logic [3:0] c_sh_dr  = 4'd4;
    localparam logic [3:0] c_ex1_dr = 4'd5;
    localparam logic [3:0] c_pa_dr  = 4'd6;
    localparam logic [3:0] c_ex2_dr = 4'd7;
    localparam logic [3:0] c_upd_dr = 4'd8;
    localparam logic [3:0] c_sel_ir = 4'd9;
    localparam logic [3:0] c_cap_ir = 4'd10;
    localparam logic [3:0] c_sh_ir  = 4'd11;
    localparam logic [3:0] c_ex1_ir = 4'd12;
    localparam logic [3:0] c_pa_ir  = 4'd13;
    localparam logic [3:0] c_ex2_ir = 4'd14;
    localparam logic [3:0] c_upd_ir = 4'd15;

    localparam logic [1:0] c_cmd_rst  = 2'b00;
    localparam logic [1:0] c_cmd_ir   = 2'b01;
    localparam logic [1:0] c_cmd_dr   = 2'b10;
    localparam logic [1:0] c_cmd_idle = 2'b11;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_BOOT = 3'd1,
        S_IDLE = 3'd2,
        S_RUN  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    function automatic logic [3:0] f_tap_next(input logic [3:0] s, input logic m);
        case (s)
            c_tlr:    f_tap_next = m ? c_tlr    : c_rti;
            c_rti:    f_tap_next = m ? c_sel_dr : c_rti;
            c_sel_dr: f_tap_next = m ? c_sel_ir : c_cap_dr;
            c_cap_dr: f_tap_next = m ? c_ex1_dr : c_sh_dr;
            c_sh_dr:  f_tap_next = m ? c_ex1_dr : c_sh_dr;
            c_ex1_dr: f_tap_next = m ? c_upd_dr : c_pa_dr;
            c_pa_dr:  f_tap_next = m ? c_ex2_dr : c_pa_dr;
            c_ex2_dr: f_tap_next = m ? c_upd_dr : c_sh_dr;
            c_upd_dr: f_tap_next = m ? c_sel_dr : c_rti;
            c_sel_ir: f_tap_next = m ? c_tlr    : c_cap_ir;
            c_cap_ir: f_tap_next = m ? c_ex1_ir : c_sh_ir;
            c_sh_ir:  f_tap_next = m ? c_ex1_ir : c_sh_ir;
            c_ex1_ir: f_tap_next = m ? c_upd_ir : c_pa_ir;
            c_pa_ir:  f_tap_next = m ? c_ex2_ir : c_pa_ir;
            c_ex2_ir: f_tap_next = m ? c_upd_ir : c_sh_ir;
            c_upd_ir: f_tap_next = m ? c_sel_dr : c_rti;
            default:  f_tap_next = c_tlr;
        endcase
    endfunction

    state_t             r_state, w_state_nxt;
    logic               r_tms, w_tms_nxt;
    logic               r_tdi, w_tdi_nxt;
    logic [3:0]         r_tap, w_tap_nxt;
    logic [1:0]         r_type;
    logic [LEN_W-1:0]   r_len;
    logic [DATA_W-1:0]  r_data;
    logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0]   r_bit, w_bit_nxt, w_nbit;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic               r_rsp_err, w_rsp_err_nxt;
    logic [DATA_W-1:0]  r_rsp_data, w_rsp_data_nxt;
    logic               w_accept, w_is_sh, w_nxt_sh, w_scan_cmd, w_len_bad, w_hold;

`ifdef JTAG_SCAN_PAUSE_EN
    assign w_hold = shift_hold;
`else
    assign w_hold = 1'b0;
`endif

    // tap_state is the state the TAP occupies this cycle; w_tap_nxt is where
    // it will be next cycle, which is what the next registered tms must steer.
    assign w_tap_nxt  = f_tap_next(r_tap, r_tms);
    assign w_is_sh    = (r_tap == c_sh_dr) || (r_tap == c_sh_ir);
    assign w_nxt_sh   = (w_tap_nxt == c_sh_dr) || (w_tap_nxt == c_sh_ir);
    assign w_nbit     = w_is_sh ? r_bit + LEN_W'(1) : r_bit;
    assign w_scan_cmd = (cmd_type == c_cmd_ir) || (cmd_type == c_cmd_dr);
    assign w_len_bad  = (cmd_len == '0) || (cmd_len > LEN_W'(DATA_W));
    assign w_accept   = (r_state == S_IDLE) && cmd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_tap       <= c_tlr;
            r_type      <= c_cmd_rst;
            r_len       <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tms       <= w_tms_nxt;
            r_tdi       <= w_tdi_nxt;
            r_tap       <= w_tap_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            if (w_accept) begin
                r_type <= cmd_type;
                r_len  <= cmd_len;
                r_data <= cmd_data;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tms_nxt       = 1'b0;
        w_tdi_nxt       = 1'b0;
        w_cnt_nxt       = r_cnt;
        w_bit_nxt       = r_bit;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_data_nxt  = r_rsp_data;

        case (r_state)
            S_INIT: w_state_nxt = S_BOOT;
            S_BOOT: w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (cmd_valid) begin
                    w_cnt_nxt      = LEN_W'(1);
                    w_bit_nxt      = '0;
                    w_rsp_data_nxt = '0;
                    if ((w_scan_cmd && w_len_bad) || (cmd_type == c_cmd_idle && cmd_len == '0)) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = w_scan_cmd;
                        w_state_nxt     = S_RESP;
                    end else begin
                        w_tms_nxt   = (cmd_type != c_cmd_idle);
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                case (r_type)
                    c_cmd_rst: begin
                        if (r_cnt == LEN_W'(6)) begin
                            w_rsp_valid_nxt = 1'b1;
                            w_state_nxt     = S_RESP;
                        end else begin
                            w_tms_nxt = (r_cnt < LEN_W'(5));
                            w_cnt_nxt = r_cnt + LEN_W'(1);
                        end
                    end
                    c_cmd_idle: begin
                        if (r_cnt == r_len) begin
                            w_rsp_valid_nxt = 1'b1;
                            w_state_nxt     = S_RESP;
                        end else begin
                            w_cnt_nxt = r_cnt + LEN_W'(1);
                        end
                    end
                    default: begin
                        // TDO is sampled only in true SHIFT cycles, never on the pause path.
                        if (w_is_sh) begin
                            w_rsp_data_nxt = r_rsp_data | (DATA_W'(tdo) << r_bit);
                            w_bit_nxt      = r_bit + LEN_W'(1);
                        end
                        if (r_tap == c_upd_dr || r_tap == c_upd_ir) begin
                            w_rsp_valid_nxt = 1'b1;
                            w_state_nxt     = S_RESP;
                        end else begin
                            case (w_tap_nxt)
                                c_sel_dr:          w_tms_nxt = (r_type == c_cmd_ir);
                                c_sh_dr, c_sh_ir:  w_tms_nxt = (w_nbit == r_len - LEN_W'(1)) || w_hold;
                                c_ex1_dr, c_ex1_ir: w_tms_nxt = (w_nbit == r_len);
                                c_pa_dr, c_pa_ir:  w_tms_nxt = !w_hold;
                                default:           w_tms_nxt = 1'b0;
                            endcase
                            w_tdi_nxt = w_nxt_sh && (|(r_data & (DATA_W'(1) << w_nbit)));
                        end
                    end
                endcase
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_data_nxt  = '0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign tms       = r_tms;
    assign tdi       = r_tdi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign tap_state = r_tap;

endmodule
`default_nettype wire
